pipelined_regfile_fwd: RTL and testbench
========================================

Name: pipelined_regfile_fwd

Overview:
- Parametrised 3-stage ID/EXE/WB integer datapath: register-file read, ALU execute, writeback.
- Adds full operand forwarding, a global hold, a decoded-instruction valid/ready input and a debug read port.
- Fed by the fetch/decode front end; drives the writeback observation bus the CPU benches monitor.

Parameters:
- DATA_W, 32, datapath and register width (>=8, power of two)
- NUM_REGS, 32, register count (power of two, >=2)
- ADDR_W, $clog2(NUM_REGS), register address width (derived)
- ZERO_REG, 1, 1 = register 0 reads as 0 and ignores writes

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-low reset
- in_valid  in  1  decoded instruction present
- in_ready  out  1  = ~hold; instruction accepted when in_valid & in_ready
- in_aluop  in  3  ALU operation
- in_alusrc  in  1  1 = operand B is in_imm, 0 = rdata2
- in_wen  in  1  instruction writes back
- in_raddr1  in  ADDR_W  source A
- in_raddr2  in  ADDR_W  source B
- in_waddr  in  ADDR_W  destination
- in_imm  in  DATA_W  sign-extended immediate
- hold  in  1  freeze entire pipeline
- exe_valid  out  1  EXE stage occupied
- aluout  out  DATA_W  combinational ALU result of EXE stage
- wb_valid  out  1  WB stage occupied and writing
- wb_addr  out  ADDR_W  WB destination
- wb_data  out  DATA_W  WB data
- wb_zero  out  1  wb_data == 0
- dbg_addr  in  ADDR_W  debug read address
- dbg_data  out  DATA_W  combinational regfile read, no forwarding

Behaviour:
- Reset: rst=0 at a rising edge clears all registers and overrides hold. Result: exe_valid=0, wb_valid=0, wb_addr=0, wb_data=0, wb_zero=1, and all NUM_REGS registers = 0.
- Cycle 0 (accept):
  - Operands are read combinationally with forwarding.
  - Operand B is muxed by in_alusrc.
  - Result, together with aluop/wen/waddr, is captured into ID/EXE at the edge.
  - Accepted with in_valid=0 loads a bubble (exe_valid=0).
- Cycle 1: ALU evaluates; aluout is valid while exe_valid=1. EXE/WB captures {valid & wen, waddr, aluout} at the edge.
- Cycle 2: wb_* visible; the regfile is written at the closing edge when wb_valid=1. Writes to addr 0 are discarded when ZERO_REG=1.
- Latency: accept to wb_valid = 2 cycles; throughput 1 instruction/cycle.
- Forwarding, per source, in priority order:
  1. EXE stage: exe_valid & exe_wen & exe_waddr==raddr gives aluout.
  2. WB stage: wb_valid & wb_addr==raddr gives wb_data.
  3. Otherwise the regfile.
  - With ZERO_REG=1, raddr==0 always yields 0 and is never forwarded.
  - Consequence: no stalls are ever required.
- ALU ops:
  - 000 ADD, 001 SUB (both wrap modulo 2^DATA_W)
  - 010 AND, 011 OR, 100 XOR
  - 101 SLT: signed compare, result 1/0 zero-extended
  - 110 SLL, 111 SRL (logical): shift amount = B[$clog2(DATA_W)-1:0]
- Hold=1:
  - in_ready=0.
  - ID/EXE and EXE/WB keep their values.
  - No regfile write occurs.
  - Outputs remain stable.
  - Forwarding sources stay consistent, so release resumes exactly.
- Simultaneous events:
  - WB writing reg X while ID reads X: the forwarded value is returned, never the stale one.
  - EXE and WB both targeting X: EXE wins.
- Reset mid-operation: in-flight instructions are dropped with no writeback.

Decomposition:
- Package pipe_pkg: ALU opcode constants ALU_ADD..ALU_SRL (3-bit), and packed structs for the ID/EXE and EXE/WB stage registers.
- Sub-module alu: combinational, parametrised by DATA_W; inputs a, b, op; output y.
- The regfile stays inline.

Test Plan:
- Reset then independent ops: r1=imm 5 (ADD r0+5), then r2=imm 7 -> wb sequence (1,5), (2,7) two cycles after each accept; dbg r1=5.
- Back-to-back RAW: r1=r0+5, r2=r1+r1, r3=r2-r1 on consecutive cycles -> wb_data 5, 10, 5 with no bubbles (EXE and WB forwarding).
- Zero register: ADD r0=r0+9 then r4=r0+r0 -> second wb_data 0, dbg r0=0, wb_zero=1.
- ALU coverage: r1=0xFFFFFFFF; SLT r1<r0 -> 1; SRL r1 by 4 -> 0x0FFFFFFF; SLL r1 by 36 (uses 4) -> 0xFFFFFFF0.
- Hold: assert hold 3 cycles with 2 instructions in flight -> outputs frozen, in_ready=0, no regfile change; after release both write back in order.
- Reset mid-flight: rst=0 with wb_valid=1 targeting r5 -> r5 stays 0, all valids 0 the next cycle.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipelined register-file datapath: ALU opcodes
// and the control portions of the ID/EXE and EXE/WB stage registers.
package pipe_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_SLL = 3'b110;
    localparam logic [2:0] ALU_SRL = 3'b111;

    // Width-independent control carried in ID/EXE; operands and the
    // destination address sit beside it because their widths are parameters.
    typedef struct packed {
        logic       valid;
        logic       wen;
        logic [2:0] aluop;
    } id_exe_ctrl_t;

    // EXE/WB control: valid already folds in the write enable, and the
    // zero flag is registered alongside the data so it is glitch-free.
    typedef struct packed {
        logic valid;
        logic zero;
    } exe_wb_ctrl_t;

endpackage

// File: rtl/alu.sv
// Combinational integer ALU used by the EXE stage.
module alu
    import pipe_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [2:0]        op,
    output logic [DATA_W-1:0] y
);

    localparam int SH_W = $clog2(DATA_W);

    logic [SH_W-1:0] shamt;
    logic            lt;

    assign shamt = b[SH_W-1:0];
    assign lt    = $signed(a) < $signed(b);

    // Select the result for the current opcode; shifts use only the low bits of b.
    always_comb begin
        y = '0;
        case (op)
            ALU_ADD: y = a + b;
            ALU_SUB: y = a - b;
            ALU_AND: y = a & b;
            ALU_OR:  y = a | b;
            ALU_XOR: y = a ^ b;
            ALU_SLT: y = {{(DATA_W-1){1'b0}}, lt};
            ALU_SLL: y = a << shamt;
            ALU_SRL: y = a >> shamt;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/pipelined_regfile_fwd.sv
// Three-stage ID/EXE/WB datapath with a register file, full EXE/WB operand
// forwarding (so no stall is ever needed), a global hold and a debug port.
module pipelined_regfile_fwd
    import pipe_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = $clog2(NUM_REGS),
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_aluop,
    input  logic              in_alusrc,
    input  logic              in_wen,
    input  logic [ADDR_W-1:0] in_raddr1,
    input  logic [ADDR_W-1:0] in_raddr2,
    input  logic [ADDR_W-1:0] in_waddr,
    input  logic [DATA_W-1:0] in_imm,
    input  logic              hold,
    output logic              exe_valid,
    output logic [DATA_W-1:0] aluout,
    output logic              wb_valid,
    output logic [ADDR_W-1:0] wb_addr,
    output logic [DATA_W-1:0] wb_data,
    output logic              wb_zero,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    logic [DATA_W-1:0] regs [NUM_REGS];

    id_exe_ctrl_t      ie_ctrl;
    logic [ADDR_W-1:0] ie_waddr;
    logic [DATA_W-1:0] ie_opa;
    logic [DATA_W-1:0] ie_opb;

    exe_wb_ctrl_t      ew_ctrl;
    logic [ADDR_W-1:0] ew_addr;
    logic [DATA_W-1:0] ew_data;

    logic [DATA_W-1:0] src_a;
    logic [DATA_W-1:0] src_b;
    logic [DATA_W-1:0] op_b;
    logic              zero_a;
    logic              zero_b;

    assign in_ready  = ~hold;
    assign exe_valid = ie_ctrl.valid;
    assign wb_valid  = ew_ctrl.valid;
    assign wb_zero   = ew_ctrl.zero;
    assign wb_addr   = ew_addr;
    assign wb_data   = ew_data;
    assign dbg_data  = regs[dbg_addr];

    assign zero_a = (ZERO_REG != 0) && (in_raddr1 == '0);
    assign zero_b = (ZERO_REG != 0) && (in_raddr2 == '0);

    alu #(.DATA_W(DATA_W)) u_alu (
        .a  (ie_opa),
        .b  (ie_opb),
        .op (ie_ctrl.aluop),
        .y  (aluout)
    );

    // Source A: hard zero, then the youngest in-flight producer, then the regfile.
    always_comb begin
        src_a = regs[in_raddr1];
        if (zero_a)
            src_a = '0;
        else if (ie_ctrl.valid && ie_ctrl.wen && ie_waddr == in_raddr1)
            src_a = aluout;
        else if (ew_ctrl.valid && ew_addr == in_raddr1)
            src_a = ew_data;
    end

    // Source B: same priority as source A.
    always_comb begin
        src_b = regs[in_raddr2];
        if (zero_b)
            src_b = '0;
        else if (ie_ctrl.valid && ie_ctrl.wen && ie_waddr == in_raddr2)
            src_b = aluout;
        else if (ew_ctrl.valid && ew_addr == in_raddr2)
            src_b = ew_data;
    end

    assign op_b = in_alusrc ? in_imm : src_b;

    // ID/EXE register: accepts a new instruction or a bubble unless held.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ie_ctrl  <= '0;
            ie_waddr <= '0;
            ie_opa   <= '0;
            ie_opb   <= '0;
        end else if (!hold) begin
            ie_ctrl.valid <= in_valid;
            ie_ctrl.wen   <= in_wen;
            ie_ctrl.aluop <= in_aluop;
            ie_waddr      <= in_waddr;
            ie_opa        <= src_a;
            ie_opb        <= op_b;
        end
    end

    // EXE/WB register: only writing instructions become visible as wb_valid.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ew_ctrl.valid <= 1'b0;
            ew_ctrl.zero  <= 1'b1;
            ew_addr       <= '0;
            ew_data       <= '0;
        end else if (!hold) begin
            ew_ctrl.valid <= ie_ctrl.valid & ie_ctrl.wen;
            ew_ctrl.zero  <= (aluout == '0);
            ew_addr       <= ie_waddr;
            ew_data       <= aluout;
        end
    end

    // Register file write at the edge closing the WB cycle; reset drops it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= '0;
        end else if (!hold && ew_ctrl.valid &&
                     !((ZERO_REG != 0) && (ew_addr == '0))) begin
            regs[ew_addr] <= ew_data;
        end
    end

endmodule

// File: tb/tb_pipelined_regfile_fwd.sv
// Directed bench for pipelined_regfile_fwd with hand-computed expectations.
module tb_pipelined_regfile_fwd;
    import pipe_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_aluop;
    logic        in_alusrc;
    logic        in_wen;
    logic [4:0]  in_raddr1;
    logic [4:0]  in_raddr2;
    logic [4:0]  in_waddr;
    logic [31:0] in_imm;
    logic        hold;
    logic        exe_valid;
    logic [31:0] aluout;
    logic        wb_valid;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        wb_zero;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;

    int npass = 0;
    int ntot  = 0;

    pipelined_regfile_fwd #(.DATA_W(32), .NUM_REGS(32), .ZERO_REG(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_aluop(in_aluop), .in_alusrc(in_alusrc), .in_wen(in_wen),
        .in_raddr1(in_raddr1), .in_raddr2(in_raddr2), .in_waddr(in_waddr),
        .in_imm(in_imm), .hold(hold), .exe_valid(exe_valid), .aluout(aluout),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
        .wb_zero(wb_zero), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic v, input logic [2:0] op, input logic src,
                         input logic wen, input logic [4:0] a1, input logic [4:0] a2,
                         input logic [4:0] wa, input logic [31:0] imm);
        in_valid  = v;
        in_aluop  = op;
        in_alusrc = src;
        in_wen    = wen;
        in_raddr1 = a1;
        in_raddr2 = a2;
        in_waddr  = wa;
        in_imm    = imm;
        tick();
    endtask

    task automatic idle();
        issue(1'b0, ALU_ADD, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0);
    endtask

    task automatic dbg(input string tag, input logic [4:0] a, input logic [31:0] exp);
        dbg_addr = a;
        #1;
        chk(tag, dbg_data, exp);
    endtask

    initial begin
        rst = 1'b0; hold = 1'b0; dbg_addr = 5'd0;
        in_valid = 1'b0; in_aluop = 3'd0; in_alusrc = 1'b0; in_wen = 1'b0;
        in_raddr1 = 5'd0; in_raddr2 = 5'd0; in_waddr = 5'd0; in_imm = 32'd0;
        tick(); tick();
        chk("rst_exe_valid", {31'd0, exe_valid}, 32'd0);
        chk("rst_wb_valid",  {31'd0, wb_valid},  32'd0);
        chk("rst_wb_addr",   {27'd0, wb_addr},   32'd0);
        chk("rst_wb_data",   wb_data,            32'd0);
        chk("rst_wb_zero",   {31'd0, wb_zero},   32'd1);
        chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
        dbg("rst_dbg_r1", 5'd1, 32'd0);
        rst = 1'b1;

        // independent ops
        issue(1, ALU_ADD, 1, 1, 5'd0, 5'd0, 5'd1, 32'd5);
        chk("t1_exe_valid", {31'd0, exe_valid}, 32'd1);
        chk("t1_aluout", aluout, 32'd5);
        issue(1, ALU_ADD, 1, 1, 5'd0, 5'd0, 5'd2, 32'd7);
        chk("t1_wb0_valid", {31'd0, wb_valid}, 32'd1);
        chk("t1_wb0_addr", {27'd0, wb_addr}, 32'd1);
        chk("t1_wb0_data", wb_data, 32'd5);
        idle();
        chk("t1_wb1_addr", {27'd0, wb_addr}, 32'd2);
        chk("t1_wb1_data", wb_data, 32'd7);
        dbg("t1_dbg_r1", 5'd1, 32'd5);
        idle();
        dbg("t1_dbg_r2", 5'd2, 32'd7);
        chk("t1_wb_drained", {31'd0, wb_valid}, 32'd0);

        // back-to-back RAW: r6=r0+5, r7=r6+r6, r8=r7-r6
        issue(1, ALU_ADD, 1, 1, 5'd0, 5'd0, 5'd6, 32'd5);
        issue(1, ALU_ADD, 0, 1, 5'd6, 5'd6, 5'd7, 32'd0);
        chk("raw_wb0", wb_data, 32'd5);
        issue(1, ALU_SUB, 0, 1, 5'd7, 5'd6, 5'd8, 32'd0);
        chk("raw_wb1", wb_data, 32'd10);
        chk("raw_wb1_valid", {31'd0, wb_valid}, 32'd1);
        idle();
        chk("raw_wb2", wb_data, 32'd5);
        chk("raw_wb2_addr", {27'd0, wb_addr}, 32'd8);
        idle(); idle();
        dbg("raw_dbg_r8", 5'd8, 32'd5);

        // EXE and WB both target r9: EXE result wins
        issue(1, ALU_ADD, 1, 1, 5'd0, 5'd0, 5'd9, 32'd1);
        issue(1, ALU_ADD, 1, 1, 5'd0, 5'd0, 5'd9, 32'd2);
        issue(1, ALU_ADD, 0, 1, 5'd9, 5'd0, 5'd10, 32'd0);
        chk("prio_exe_wins", aluout, 32'd2);
        idle(); idle(); idle();

        // zero register
        issue(1, ALU_ADD, 1, 1, 5'd0, 5'd0, 5'd0, 32'd9);
        issue(1, ALU_ADD, 0, 1, 5'd0, 5'd0, 5'd4, 32'd0);
        chk("zero_wb_r0_data", wb_data, 32'd9);
        idle();
        chk("zero_wb_r4", wb_data, 32'd0);
        chk("zero_wb_zero", {31'd0, wb_zero}, 32'd1);
        idle();
        dbg("zero_dbg_r0", 5'd0, 32'd0);

        // ALU coverage
        issue(1, ALU_ADD, 1, 1, 5'd0, 5'd0, 5'd1, 32'hFFFF_FFFF);
        issue(1, ALU_SLT, 0, 1, 5'd1, 5'd0, 5'd11, 32'd0);
        chk("alu_slt_neg", aluout, 32'd1);
        issue(1, ALU_SRL, 1, 1, 5'd1, 5'd0, 5'd12, 32'd4);
        chk("alu_srl", aluout, 32'h0FFF_FFFF);
        issue(1, ALU_SLL, 1, 1, 5'd1, 5'd0, 5'd13, 32'd36);
        chk("alu_sll", aluout, 32'hFFFF_FFF0);
        issue(1, ALU_XOR, 1, 1, 5'd1, 5'd0, 5'd14, 32'h0F0F_0F0F);
        chk("alu_xor", aluout, 32'hF0F0_F0F0);
        issue(1, ALU_AND, 1, 1, 5'd1, 5'd0, 5'd15, 32'h00FF_00FF);
        chk("alu_and", aluout, 32'h00FF_00FF);
        issue(1, ALU_OR, 1, 1, 5'd0, 5'd0, 5'd16, 32'h12);
        chk("alu_or", aluout, 32'h0000_0012);
        issue(1, ALU_SLT, 0, 1, 5'd0, 5'd1, 5'd17, 32'd0);
        chk("alu_slt_pos", aluout, 32'd0);
        issue(1, ALU_SUB, 1, 1, 5'd0, 5'd0, 5'd18, 32'd1);
        chk("alu_sub_wrap", aluout, 32'hFFFF_FFFF);
        idle(); idle(); idle();
        dbg("alu_dbg_r13", 5'd13, 32'hFFFF_FFF0);

        // hold with two instructions in flight
        issue(1, ALU_ADD, 1, 1, 5'd0, 5'd0, 5'd20, 32'h20);
        issue(1, ALU_ADD, 1, 1, 5'd0, 5'd0, 5'd21, 32'h21);
        hold = 1'b1;
        in_waddr = 5'd22; in_imm = 32'h55; in_valid = 1'b1;
        #1;
        chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("hold_wb_addr", {27'd0, wb_addr}, 32'd20);
            chk("hold_wb_data", wb_data, 32'h20);
            chk("hold_aluout", aluout, 32'h21);
            chk("hold_exe_valid", {31'd0, exe_valid}, 32'd1);
            dbg("hold_dbg_r20", 5'd20, 32'd0);
        end
        hold = 1'b0;
        idle();
        chk("rel_wb_addr", {27'd0, wb_addr}, 32'd21);
        chk("rel_wb_data", wb_data, 32'h21);
        dbg("rel_dbg_r20", 5'd20, 32'h20);
        idle();
        dbg("rel_dbg_r21", 5'd21, 32'h21);
        dbg("rel_dbg_r22", 5'd22, 32'd0);

        // reset mid-flight
        issue(1, ALU_ADD, 1, 1, 5'd0, 5'd0, 5'd5, 32'h5A);
        in_valid = 1'b0;
        tick();
        chk("mid_wb_valid_pre", {31'd0, wb_valid}, 32'd1);
        rst = 1'b0;
        tick();
        chk("mid_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("mid_exe_valid", {31'd0, exe_valid}, 32'd0);
        rst = 1'b1;
        idle();
        dbg("mid_dbg_r5", 5'd5, 32'd0);
        dbg("mid_dbg_r1", 5'd1, 32'd0);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
